// File: rtl/mfe_led7seg_74hc595_receiver.sv
// Far-end model of the 74HC595 chain driven by the 7-segment controller.
// Shifts DIO in on SCLK rising edges and latches the frame on RCLK rising edges.
// Each latched word is presented with a one-cycle valid pulse and a frame-error flag.
// Good frames also refresh a per-digit segment frame buffer.
module mfe_led7seg_74hc595_receiver #(
  parameter int DIG_NUM   = 8,
  parameter int SEG_NUM   = 8,
  parameter int DAT_WIDTH = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         rclk,
  input  logic                         dio,
  output logic [DAT_WIDTH-1:0]         dat,
  output logic                         vld,
  output logic                         err,
  output logic [DIG_NUM*SEG_NUM-1:0]   seg_buf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] FRAME_LEN = CNT_WIDTH'(DAT_WIDTH);

  // _p0/_p1 form the synchronizer; _p2 is the edge-detect delay.
  logic sclk_p0, sclk_p1, sclk_p2;
  logic rclk_p0, rclk_p1, rclk_p2;
  logic dio_p0, dio_p1;

  logic                 sclk_rise;
  logic                 rclk_rise;
  logic                 frame_bad;
  logic [DAT_WIDTH-1:0] sreg;
  logic [CNT_WIDTH-1:0] bit_cnt;

  // Overwrite the segment field of every digit selected in a latched word.
  function automatic logic [DIG_NUM*SEG_NUM-1:0] seg_merge(
    input logic [DIG_NUM*SEG_NUM-1:0] cur,
    input logic [DAT_WIDTH-1:0]       word
  );
    logic [DIG_NUM*SEG_NUM-1:0] res;
    res = cur;
    for (int d = 0; d < DIG_NUM; d++) begin
      if (word[DAT_WIDTH-DIG_NUM+d]) res[d*SEG_NUM +: SEG_NUM] = word[SEG_NUM-1:0];
    end
    return res;
  endfunction

  // Synchronize the link lines.
  // The clock lines reset high, so a line that idles high produces no edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_p0 <= 1'b1;
      sclk_p1 <= 1'b1;
      sclk_p2 <= 1'b1;
      rclk_p0 <= 1'b1;
      rclk_p1 <= 1'b1;
      rclk_p2 <= 1'b1;
      dio_p0  <= 1'b0;
      dio_p1  <= 1'b0;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      rclk_p0 <= rclk;
      rclk_p1 <= rclk_p0;
      rclk_p2 <= rclk_p1;
      dio_p0  <= dio;
      dio_p1  <= dio_p0;
    end
  end

  // --- edge detect on synchronized lines ---
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign rclk_rise = rclk_p1 & ~rclk_p2;
  assign frame_bad = (bit_cnt != FRAME_LEN);

  // Shift register: MSB first; a coincident latch still sees the pre-shift contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (sclk_rise) begin
      sreg <= {sreg[DAT_WIDTH-2:0], dio_p1};
    end
  end

  // Bit counter: saturating; a coincident shift counts as bit 1 of the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (rclk_rise) begin
      bit_cnt <= sclk_rise ? CNT_WIDTH'(1) : '0;
    end else if (sclk_rise && (bit_cnt != CNT_MAX)) begin
      bit_cnt <= bit_cnt + CNT_WIDTH'(1);
    end
  end

  // Latch: present the frame with its valid pulse and length check.
  // err is forced low outside the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat <= '0;
      vld <= 1'b0;
      err <= 1'b0;
    end else begin
      vld <= rclk_rise;
      err <= rclk_rise & frame_bad;
      if (rclk_rise) dat <= sreg;
    end
  end

  // Frame buffer: only frames of the correct length update the selected digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_buf <= '0;
    end else if (rclk_rise && !frame_bad) begin
      seg_buf <= seg_merge(seg_buf, sreg);
    end
  end

endmodule

// File: tb/tb_mfe_led7seg_74hc595_receiver.sv
// Directed bench for the 74HC595 link receiver.
module tb_mfe_led7seg_74hc595_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        rclk = 1'b0;
  logic        dio = 1'b0;
  logic [15:0] dat;
  logic        vld;
  logic        err;
  logic [63:0] seg_buf;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_total = 0;

  logic [15:0] got_dat;
  logic        got_err;
  int          got_pulses;
  int          vld_mark;

  mfe_led7seg_74hc595_receiver #(
    .DIG_NUM(8), .SEG_NUM(8), .DAT_WIDTH(16), .CNT_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio),
    .dat(dat), .vld(vld), .err(err), .seg_buf(seg_buf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (vld) vld_total++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bit per sclk period: 4 cycles low with dio set, then 4 cycles high.
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      dio  = val[i];
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  // rclk pulse; record the vld pulse(s) seen within a bounded window.
  task automatic do_latch(output logic [15:0] d, output logic e, output int pulses);
    d = 'x;
    e = 'x;
    pulses = 0;
    rclk = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (vld) begin
        pulses++;
        d = dat;
        e = err;
      end
    end
    rclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_check(input string tag, input logic [15:0] exp_dat,
                             input logic exp_err, input logic [63:0] exp_seg);
    do_latch(got_dat, got_err, got_pulses);
    check({tag, "_pulses"}, 64'(got_pulses), 64'd1);
    check({tag, "_dat"}, 64'(got_dat), 64'(exp_dat));
    check({tag, "_err"}, 64'(got_err), 64'(exp_err));
    check({tag, "_seg"}, seg_buf, exp_seg);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dat", 64'(dat), 64'd0);
    check("rst_vld", 64'(vld), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_seg", seg_buf, 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame: digit 2 <- 6D
    send_bits(32'h046D, 16);
    frame_check("f046d", 16'h046D, 1'b0, 64'h0000_0000_006D_0000);

    // Multi-select: digits 7 and 0 <- 3F
    send_bits(32'h813F, 16);
    frame_check("f813f", 16'h813F, 1'b0, 64'h3F00_0000_006D_003F);

    // Short frame: 15 bits behind the leftover LSB (1) of 813F -> 8123
    send_bits(32'h0123, 15);
    frame_check("short", 16'h8123, 1'b1, 64'h3F00_0000_006D_003F);

    // Long frame: 17 bits, the leading 1 falls off the top
    send_bits(32'h1_0240, 17);
    frame_check("long", 16'h0240, 1'b1, 64'h3F00_0000_006D_003F);

    // Correct frame after the long one: digit 1 <- 79
    send_bits(32'h0279, 16);
    frame_check("after_long", 16'h0279, 1'b0, 64'h3F00_0000_006D_793F);

    // Reset mid-frame: outputs clear at once
    send_bits(32'h55, 7);
    rst = 1'b0;
    #1;
    check("midrst_dat", 64'(dat), 64'd0);
    check("midrst_vld", 64'(vld), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    check("midrst_seg", seg_buf, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(32'h0106, 16);
    frame_check("post_rst", 16'h0106, 1'b0, 64'h0000_0000_0000_0006);

    // Controller-style back-to-back frames
    send_bits(32'h0106, 16);
    frame_check("loop1", 16'h0106, 1'b0, 64'h0000_0000_0000_0006);
    send_bits(32'h024F, 16);
    frame_check("loop2", 16'h024F, 1'b0, 64'h0000_0000_0000_4F06);

    // Total vld pulses equal the number of latches (8)
    check("vld_total", 64'(vld_total), 64'd8);

    // rclk idling high through reset release gives no vld
    rst  = 1'b0;
    rclk = 1'b1;
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    vld_mark = vld_total;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_high_vld", 64'(vld_total - vld_mark), 64'd0);
    check("idle_high_dat", 64'(dat), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mfe_led7seg_74hc595_receiver.md
# mfe_led7seg_74hc595_receiver

Serial receiver for the 7-segment 74HC595 link: samples the SCLK/RCLK/DIO lines produced by the LED 7-segment 74HC595 controller and behaves like the 595 chain on the far end. It shifts DIO in on SCLK rising edges and latches the frame on RCLK rising edges. It presents the latched word with a one-cycle valid pulse and a frame-error flag, and maintains a per-digit segment frame buffer. Used as an on-board loopback checker and as the input stage when the FPGA itself is the display slave.

## Interface
- DIG_NUM, 8: number of digits; width of the digit-select field.
- SEG_NUM, 8: segments per digit; width of the segment field.
- DAT_WIDTH, 16: bits per frame. Must equal DIG_NUM + SEG_NUM.
- CNT_WIDTH, 5: bit-counter width. Must be at least clog2(DAT_WIDTH) + 1.

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- sclk  in  1  serial shift clock from the link; asynchronous to clk.
- rclk  in  1  latch clock from the link; asynchronous to clk.
- dio  in  1  serial data, MSB first.
- dat  out  DAT_WIDTH  last latched frame. [DAT_WIDTH-1 -: DIG_NUM] is digit select (one-hot, active-high); [SEG_NUM-1:0] is the segment pattern.
- vld  out  1  one-cycle pulse: dat and err have been updated.
- err  out  1  frame error for the frame flagged by vld; valid only while vld=1, otherwise 0.
- seg_buf  out  DIG_NUM*SEG_NUM  frame buffer. Digit d occupies [d*SEG_NUM +: SEG_NUM].

## Operation
- Input conditioning:
  - sclk, rclk and dio each pass through a 2-FF synchronizer, followed by one delay register for edge detection.
  - The sclk and rclk chains reset to 1, so a line that is high at reset release produces no false edge. The dio chain resets to 0.
- Rising edge is detected when the synchronized value is 1 and the delayed value is 0. Falling edges are ignored.
- Shift (on an sclk rising edge):
  - sreg <= {sreg[DAT_WIDTH-2:0], dio_sync}.
  - bit_cnt increments and saturates at its all-ones value.
- Latch (on an rclk rising edge):
  - dat <= sreg; vld <= 1.
  - err <= (bit_cnt != DAT_WIDTH).
  - bit_cnt <= 0.
- Frame buffer update:
  - Applies only when err is 0.
  - For every digit d whose digit-select bit d of the latched word is 1, seg_buf[d*SEG_NUM +: SEG_NUM] <= latched segment field.
  - Multiple set bits update all selected digits. A zero select field updates nothing.
  - On an erroneous frame seg_buf is unchanged.
- Simultaneous sclk and rclk edges in the same cycle:
  - The latch captures the pre-shift sreg, and err uses the pre-shift bit_cnt.
  - The shift still happens, and bit_cnt becomes 1; the bit belongs to the next frame.
- No backpressure: vld is informational only. Consecutive frames overwrite dat.
- Asynchronous reset (rst=0), including mid-frame:
  - Clears sreg, bit_cnt, dat, vld, err and seg_buf immediately.
  - The partial frame is discarded; the next frame counts from bit 0.

## Timing
- Reset values: dat=0, vld=0, err=0, seg_buf=0. Internal: sreg=0, bit_cnt=0.
- Latency: an external rclk rising edge that meets setup before clk edge k produces vld=1 during the cycle after clk edge k+2, i.e. within 3 clk cycles.
  - dat, err and seg_buf update on that same edge.
- vld is high for exactly 1 cycle per detected rclk rising edge.
- Line requirements:
  - sclk and rclk high and low phases each at least 3 clk cycles.
  - dio stable for at least 3 clk cycles before and 1 clk cycle after each sclk rising edge.
  - Violations give undefined data but must not lock up the block.
- Throughput: at most one latch every 6 clk cycles (limited by the rclk minimum period).

## Test plan
- Single frame 16'h046D: 16 sclk pulses at 4-cycle half-period, then an rclk pulse -> vld=1 for 1 cycle, dat=16'h046D, err=0, seg_buf digit 2 = 8'h6D, all other digits 0.
- Multi-select 16'h813F after the frame above -> digits 0 and 7 = 8'h3F, digit 2 still 8'h6D, err=0.
- Short frame of 15 bits, then rclk -> err=1 with vld, dat = 15 bits shifted into the previous sreg, seg_buf unchanged.
- Long frame of 17 bits 1,16'h0240 -> err=1, dat=16'h0240, seg_buf unchanged. A following correct 16-bit frame gives err=0.
- rst pulsed low after 7 bits of a frame -> all outputs 0 immediately. A fresh 16-bit frame 16'h0106 then latches with err=0 and digit 0 = 8'h06.
- Loopback with the 74HC595 controller (DIV_WIDTH=2):
  - Send 16'h0106, then 16'h024F -> two vld pulses with matching dat, err=0 both times.
  - The controller's idle-high rclk at start-up produces no spurious vld.
